// File: rtl/miner_run_monitor.sv
// Run controller/checker: sequences DUT reset, bounds the run with a timeout and
// records the first-completion cycle of each done channel. Optional: MONITOR_HEARTBEAT_EN.
module miner_run_monitor #(
  parameter int N_CH           = 4,
  parameter int CNT_W          = 32,
  parameter int RESET_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 40,
  parameter int LED_DIV_W      = 24,
  localparam int SEL_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [N_CH-1:0]   ch_done,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic              dut_reset,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              timed_out,
  output logic [N_CH-1:0]   done_mask,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  rd_cycle,
  output logic              led
);

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RESET_DUT, S_RUN, S_FINISH} state_e;

  state_e             state_q;
  logic [RC_W-1:0]    rc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [N_CH-1:0]    mask_q;
  logic [CNT_W-1:0]   cap_q [N_CH];
  logic               pass_q;
  logic               to_q;
`ifdef MONITOR_HEARTBEAT_EN
  logic [LED_DIV_W-1:0] div_q;
  logic                 led_q;
`endif

  logic [N_CH-1:0] new_d;
  logic [N_CH-1:0] mask_d;
  logic            all_d;

  always_comb begin
    new_d  = ch_done & ~mask_q;
    mask_d = mask_q | ch_done;
    all_d  = &mask_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rc_q    <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      pass_q  <= 1'b0;
      to_q    <= 1'b0;
      for (int i = 0; i < N_CH; i++) cap_q[i] <= '0;
`ifdef MONITOR_HEARTBEAT_EN
      div_q   <= '0;
      led_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_FINISH: begin
          if (start) begin
            state_q <= S_RESET_DUT;
            rc_q    <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            pass_q  <= 1'b0;
            to_q    <= 1'b0;
            for (int i = 0; i < N_CH; i++) cap_q[i] <= '0;
`ifdef MONITOR_HEARTBEAT_EN
            led_q   <= 1'b0;
`endif
          end
        end
        S_RESET_DUT: begin
          if (rc_q == RC_LAST) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
`ifdef MONITOR_HEARTBEAT_EN
            div_q   <= '0;
            led_q   <= 1'b0;
`endif
          end else begin
            rc_q <= rc_q + RC_W'(1);
          end
        end
        S_RUN: begin
          mask_q <= mask_d;
          for (int i = 0; i < N_CH; i++) begin
            if (new_d[i]) cap_q[i] <= cnt_q;
          end
          // Completion takes priority over the timeout in the final cycle.
          if (all_d) begin
            state_q <= S_FINISH;
            pass_q  <= 1'b1;
`ifdef MONITOR_HEARTBEAT_EN
            led_q   <= 1'b1;
`endif
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_FINISH;
            to_q    <= 1'b1;
`ifdef MONITOR_HEARTBEAT_EN
            led_q   <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
`ifdef MONITOR_HEARTBEAT_EN
            div_q <= div_q + LED_DIV_W'(1);
            if (&div_q) led_q <= ~led_q;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Pad the capture bank to a power of two so any rd_sel value is a legal index.
  logic [CNT_W-1:0] cap_ext [2**SEL_W];
  for (genvar g = 0; g < 2**SEL_W; g++) begin : g_cap
    if (g < N_CH) begin : g_real
      assign cap_ext[g] = cap_q[g];
    end else begin : g_pad
      assign cap_ext[g] = '0;
    end
  end

  assign rd_cycle    = cap_ext[rd_sel];
  assign dut_reset   = (state_q != S_RUN);
  assign running     = (state_q == S_RUN);
  assign done        = (state_q == S_FINISH);
  assign pass        = pass_q;
  assign timed_out   = to_q;
  assign done_mask   = mask_q;
  assign cycle_count = cnt_q;
`ifdef MONITOR_HEARTBEAT_EN
  assign led         = led_q;
`else
  assign led         = pass_q;
`endif

endmodule

// File: tb/tb_miner_run_monitor.sv
// Directed bench for miner_run_monitor with a scoreboard of expected run results.
module tb_miner_run_monitor;
  localparam int N  = 4;
  localparam int CW = 32;
  localparam int RC = 4;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [N-1:0]  ch_done;
  logic [1:0]    rd_sel;
  logic          dut_reset, running, done, pass, timed_out, led;
  logic [N-1:0]  done_mask;
  logic [CW-1:0] cycle_count, rd_cycle;

  always #5 clk = ~clk;

  miner_run_monitor #(
    .N_CH(N), .CNT_W(CW), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO), .LED_DIV_W(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ch_done(ch_done), .rd_sel(rd_sel),
    .dut_reset(dut_reset), .running(running), .done(done), .pass(pass),
    .timed_out(timed_out), .done_mask(done_mask), .cycle_count(cycle_count),
    .rd_cycle(rd_cycle), .led(led)
  );

  typedef struct packed {
    logic                  pass;
    logic                  to;
    logic [N-1:0]          mask;
    logic [CW-1:0]         cnt;
    logic [N-1:0][CW-1:0]  cap;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   sa[N];
  int   sb[N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".dut_reset"}, dut_reset, 1'b1);
    chk({tag, ".running"}, running, 1'b0);
    chk({tag, ".done"}, done, 1'b0);
    chk({tag, ".pass"}, pass, 1'b0);
    chk({tag, ".timed_out"}, timed_out, 1'b0);
    chk({tag, ".mask"}, done_mask, '0);
    chk({tag, ".cnt"}, cycle_count, '0);
    chk({tag, ".led"}, led, 1'b0);
    for (int i = 0; i < N; i++) begin
      rd_sel = 2'(i);
      #1;
      chk($sformatf("%s.cap%0d", tag, i), rd_cycle, '0);
    end
  endtask

  task automatic run_case(input string tag, input bit noise);
    exp_t e;
    exp_t got;
    int   first[N];
    int   mx;
    bit   all;
    int   r;
    logic exp_led;
    for (int i = 0; i < N; i++) begin
      first[i] = -1;
      if (sa[i] >= 0 && sa[i] < TO) first[i] = sa[i];
      if (sb[i] >= 0 && sb[i] < TO && (first[i] < 0 || sb[i] < first[i])) first[i] = sb[i];
    end
    all = 1'b1;
    mx  = 0;
    for (int i = 0; i < N; i++) begin
      if (first[i] < 0) all = 1'b0;
      else if (first[i] > mx) mx = first[i];
    end
    e.pass = all;
    e.to   = !all;
    e.cnt  = all ? CW'(mx) : CW'(TO - 1);
    for (int i = 0; i < N; i++) begin
      e.mask[i] = (first[i] >= 0);
      e.cap[i]  = (first[i] >= 0) ? CW'(first[i]) : '0;
    end
    sb_q.push_back(e);

    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, ".clr_dut_reset"}, dut_reset, 1'b1);
    chk({tag, ".clr_done"}, done, 1'b0);
    chk({tag, ".clr_pass"}, pass, 1'b0);
    chk({tag, ".clr_to"}, timed_out, 1'b0);
    chk({tag, ".clr_mask"}, done_mask, '0);
    chk({tag, ".clr_cnt"}, cycle_count, '0);
    for (int k = 1; k < RC; k++) begin
      if (noise) begin
        start   = 1'b1;
        ch_done = '1;
      end
      step();
      chk($sformatf("%s.rst_hold%0d", tag, k), dut_reset, 1'b1);
    end
    start   = 1'b0;
    ch_done = '0;
    step();
    chk({tag, ".run_dut_reset"}, dut_reset, 1'b0);
    chk({tag, ".run_running"}, running, 1'b1);
    chk({tag, ".run_mask0"}, done_mask, '0);

    r = 0;
    while (r < TO + 10) begin
      chk($sformatf("%s.cnt@%0d", tag, r), cycle_count, CW'(r));
      chk($sformatf("%s.running@%0d", tag, r), running, 1'b1);
`ifdef MONITOR_HEARTBEAT_EN
      exp_led = ((r >> 3) & 1) != 0;
`else
      exp_led = 1'b0;
`endif
      chk($sformatf("%s.led@%0d", tag, r), led, exp_led);
      for (int i = 0; i < N; i++) ch_done[i] = (r == sa[i]) || (r == sb[i]);
      start = noise && (r == 2);
      step();
      r++;
      if (done === 1'b1) break;
    end
    ch_done = '0;
    start   = 1'b0;
    chk({tag, ".latency"}, r, e.cnt + 1);

    got = sb_q.pop_front();
    chk({tag, ".done"}, done, 1'b1);
    chk({tag, ".running"}, running, 1'b0);
    chk({tag, ".dut_reset"}, dut_reset, 1'b1);
    chk({tag, ".pass"}, pass, got.pass);
    chk({tag, ".timed_out"}, timed_out, got.to);
    chk({tag, ".mask"}, done_mask, got.mask);
    chk({tag, ".cnt"}, cycle_count, got.cnt);
    chk({tag, ".led"}, led, got.pass);
    for (int i = 0; i < N; i++) begin
      rd_sel = 2'(i);
      #1;
      chk($sformatf("%s.cap%0d", tag, i), rd_cycle, got.cap[i]);
    end
    ch_done = '1;
    step();
    ch_done = '0;
    chk({tag, ".hold_mask"}, done_mask, got.mask);
    chk({tag, ".hold_cnt"}, cycle_count, got.cnt);
    chk({tag, ".hold_done"}, done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    ch_done = '0;
    rd_sel  = '0;
    step();
    step();
    chk_reset_vals("por");
    reset   = 1'b0;
    ch_done = '1;
    repeat (5) begin
      step();
      chk_reset_vals("idle");
    end
    ch_done = '0;

    sa = '{3, 7, 7, 12};
    sb = '{-1, -1, -1, -1};
    run_case("stag", 1'b0);

    sa = '{1, 4, -1, 9};
    run_case("tmo", 1'b1);

    sa = '{0, 10, 20, 39};
    run_case("bnd", 1'b0);

    sa = '{5, 2, 3, 15};
    sb = '{9, -1, -1, -1};
    run_case("dup", 1'b1);

    // Reset in the middle of a run.
    sa = '{3, -1, -1, -1};
    sb = '{-1, -1, -1, -1};
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (RC) step();
    for (int r = 0; r < 10; r++) begin
      ch_done[0] = (r == 3);
      step();
    end
    ch_done = '0;
    chk("mrst.cnt10", cycle_count, CW'(10));
    chk("mrst.mask", done_mask, 4'b0001);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_vals("mrst");
    step();
    chk_reset_vals("mrst_idle");

    sa = '{1, 1, 1, 1};
    run_case("post", 1'b1);
    chk("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
